// File: rtl/dec_grant_arbiter.sv
// rtl/dec_grant_arbiter.sv - four-way round-robin arbiter with quantum-limited grants
// Produces registered select/enable for a 2-to-4 decoder plus the matching one-hot grant.
module dec_grant_arbiter #(
    parameter int QUANTUM = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] gnt,
    output logic       expire
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] LAST = 8'(QUANTUM - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [7:0] cnt;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       owner_req;
    logic       quantum_done;

    // Scan from the far end back toward ptr so the index closest to ptr wins.
    always_comb begin
        pick = ptr;
        cand = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                pick = cand;
            end
        end
    end

    assign owner_req    = req[sel];
    assign quantum_done = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sel    <= 2'd0;
            en     <= 1'b0;
            gnt    <= 4'b0000;
            expire <= 1'b0;
            ptr    <= 2'd0;
            cnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    expire <= 1'b0;
                    if (req != 4'b0000) begin
                        sel   <= pick;
                        gnt   <= 4'b0001 << pick;
                        en    <= 1'b1;
                        cnt   <= 8'd0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req || quantum_done) begin
                        // A request drop on the last quantum cycle is not an expiry.
                        expire <= owner_req;
                        en     <= 1'b0;
                        gnt    <= 4'b0000;
                        ptr    <= sel + 2'd1;
                        cnt    <= 8'd0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: doc/dec_grant_arbiter.md
# dec_grant_arbiter

Four-way round-robin arbiter that shares one decoded resource (bus slot, register-bank port, peripheral select) between four requesters. It produces the 2-bit select and enable that drive the team's 2-to-4 enable decoder, plus a registered one-hot grant equal to that decoder's output. Each grant lasts until the owner drops its request or a fixed quantum expires, so no requester can starve the others. It sits between the requesting units and the select decoder in the CPU datapath.

## Interface

Parameters:

- QUANTUM, default 8: maximum consecutive grant cycles per ownership. Legal range 1..255.

Ports:

- clk  input  1  system clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines. Bit i is requester i, level-sensitive.
- sel  output  2  granted index. sel[0] drives decoder I0 (LSB), sel[1] drives I1.
- en  output  1  grant valid. Drives the decoder En input.
- gnt  output  4  one-hot grant. Equals en ? (4'b0001 << sel) : 4'b0000.
- expire  output  1  one-cycle pulse: the current grant was revoked by quantum expiry.

## Operation

- Internal state:
  - 2-bit round-robin pointer ptr.
  - 8-bit hold counter cnt.
  - FSM with states IDLE and GRANT.
- Every output comes from a flop. There is no combinational path from req to any output.
- Reset: on any edge with rst=1, the block enters IDLE with sel=0, en=0, gnt=0, expire=0, ptr=0, cnt=0. rst overrides all other activity, including reset in the middle of a GRANT.
- IDLE:
  - en=0.
  - If req≠0, search the indices ptr, ptr+1, ptr+2, ptr+3 (mod 4), in that order. The first asserted index becomes sel.
  - Set en=1, cnt=0, and go to GRANT.
  - If req=0, stay in IDLE. sel holds its last value.
- GRANT:
  - en=1 and sel is stable for the whole ownership.
  - Release condition: req[sel]=0, or cnt=QUANTUM-1.
  - If released: go to IDLE, en=0, ptr=sel+1 (mod 4, so 3 wraps to 0), cnt=0.
  - If not released: cnt=cnt+1.
  - expire=1 for exactly one cycle, coincident with the en=0 cycle, only when the release was due to the quantum and req[sel] was still 1.
  - When the request drop and the quantum expiry happen in the same cycle, the release counts as a request drop: expire=0.
- Other requests arriving during GRANT have no effect. There is no preemption.
- Every ownership is followed by at least one IDLE cycle with en=0. This dead cycle prevents select glitches between owners.
- A requester whose grant expired, and which keeps requesting, is the lowest priority in the next arbitration. It regains the resource next only if nobody else is requesting.

## Timing

- Grant latency: req sampled high at edge N while in IDLE gives en=1 and a valid sel after edge N. The grant is visible for cycle N+1.
- Release latency:
  - req[sel] sampled low at edge M gives en=0 after edge M.
  - Maximum ownership is exactly QUANTUM cycles with en=1.
- QUANTUM=1: every grant lasts one cycle. expire pulses whenever the owner is still requesting.
- Turnaround between two owners is 1 dead cycle. Steady-state throughput with continuous requests is QUANTUM grant cycles per QUANTUM+1 cycles.
- Requesters must hold req high until they see their gnt bit. A pulse dropped while in GRANT for another requester is lost.
- The ptr update and the cnt clear happen on the same edge as the en fall.

## Test plan

- Reset/idle:
  - Hold rst=1 for 3 cycles with req=4'b1111; sel, en, gnt and expire stay 0.
  - Release rst with req=0; en stays 0 for 10 cycles.
- Single request, early drop:
  - QUANTUM=4. Raise req=4'b0100 at cycle 0, drop it at cycle 2.
  - Expect sel=2, en=1, gnt=4'b0100 during cycles 1-2.
  - Expect en=0 at cycle 3, expire never asserts, and ptr=3.
- Quantum expiry and rotation:
  - QUANTUM=4. Hold req=4'b1111 continuously.
  - Expect grants to indices 0, 1, 2, 3, 0, each exactly 4 cycles with en=1, separated by one en=0 cycle.
  - Expect expire=1 in each gap.
- Wrap and priority:
  - After a grant to 3, present req=4'b1001.
  - Expect index 0 granted before 3.
  - Then hold only req=4'b1000 with QUANTUM=2: index 3 is regranted after each 1-cycle gap, with expire=1 each time.
- Simultaneous drop and expiry:
  - QUANTUM=4. The owner drops req on its 4th grant cycle.
  - Expect en=0 on the next cycle with expire=0.
- Reset mid-grant:
  - Assert rst during cycle 2 of a grant to index 2.
  - Expect en=0, gnt=0, ptr=0 on the next cycle.
  - After release with req=4'b0101, index 0 is granted first.
